// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-ported, fixed-latency unified memory between the fetch
// stage and the memory stage. One access is in flight at a time: grant in
// IDLE, wait out the memory latency in WAIT, pulse the owner's valid in DONE.
// Data accesses normally win, but a fetch that has watched MAX_DSTREAK
// consecutive data grants is served next so the front end cannot starve.
module mem_port_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MEM_LAT     = 2,
    parameter int MAX_DSTREAK = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,
    output logic              stall_f,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_valid,
    output logic              stall_m,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);
    localparam int CNT_W = $clog2(MEM_LAT + 1);
    localparam int STK_W = $clog2(MAX_DSTREAK + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LAT);
    localparam logic [STK_W-1:0] STK_MAX  = STK_W'(MAX_DSTREAK);
    localparam logic OWNER_FETCH = 1'b0;
    localparam logic OWNER_DATA  = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_r;
    state_t            state_nxt_s;
    logic [CNT_W-1:0]  cnt_r;
    logic [STK_W-1:0]  dstreak_r;
    logic              owner_r;
    logic              owner_we_r;
    logic [DATA_W-1:0] if_rdata_r;
    logic [DATA_W-1:0] dm_rdata_r;
    logic              if_valid_r;
    logic              dm_valid_r;
    logic              req_any_s;
    logic              data_win_s;
    logic              grant_s;
    logic              capture_s;

    // Arbitration decision, grant qualification and read-data capture point.
    always_comb begin
        req_any_s  = if_req | dm_req;
        data_win_s = 1'b0;
        grant_s    = 1'b0;
        capture_s  = 1'b0;
        // Data wins unless fetch is also waiting and the streak is used up.
        if (dm_req && (!if_req || (dstreak_r != STK_MAX))) begin
            data_win_s = 1'b1;
        end else begin
            data_win_s = 1'b0;
        end
        // The reset term keeps the strobe low while reset is held, even
        // though the state register already sits in IDLE.
        if ((state_r == IDLE) && req_any_s && reset) begin
            grant_s = 1'b1;
        end else begin
            grant_s = 1'b0;
        end
        if ((state_r == WAIT) && (cnt_r == CNT_LAST)) begin
            capture_s = 1'b1;
        end else begin
            capture_s = 1'b0;
        end
    end

    // Next-state logic for the grant / wait / done sequence.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (grant_s) begin
                    state_nxt_s = WAIT;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            WAIT: begin
                if (capture_s) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = WAIT;
                end
            end
            DONE:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Memory-side strobe, address and write data, driven from the winner.
    always_comb begin
        mem_en    = grant_s;
        mem_we    = 1'b0;
        mem_addr  = if_addr;
        mem_wdata = dm_wdata;
        if (data_win_s) begin
            mem_addr = dm_addr;
            mem_we   = grant_s & dm_we;
        end else begin
            mem_addr = if_addr;
            mem_we   = 1'b0;
        end
    end

    // State register and latency counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
            cnt_r   <= {CNT_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            if (grant_s) begin
                cnt_r <= CNT_W'(1);
            end else if (state_r == WAIT) begin
                cnt_r <= cnt_r + CNT_W'(1);
            end else begin
                cnt_r <= {CNT_W{1'b0}};
            end
        end
    end

    // Owner bookkeeping and the data-streak counter used for fairness.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner_r    <= OWNER_FETCH;
            owner_we_r <= 1'b0;
            dstreak_r  <= {STK_W{1'b0}};
        end else if (grant_s) begin
            if (data_win_s) begin
                owner_r    <= OWNER_DATA;
                owner_we_r <= dm_we;
                if (!if_req) begin
                    dstreak_r <= {STK_W{1'b0}};
                end else if (dstreak_r != STK_MAX) begin
                    dstreak_r <= dstreak_r + STK_W'(1);
                end else begin
                    dstreak_r <= dstreak_r;
                end
            end else begin
                owner_r    <= OWNER_FETCH;
                owner_we_r <= 1'b0;
                dstreak_r  <= {STK_W{1'b0}};
            end
        end else begin
            owner_r    <= owner_r;
            owner_we_r <= owner_we_r;
            dstreak_r  <= dstreak_r;
        end
    end

    // Completion pulses and per-port read-data registers; write completions
    // pulse dm_valid but leave dm_rdata untouched.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            if_valid_r <= 1'b0;
            dm_valid_r <= 1'b0;
            if_rdata_r <= {DATA_W{1'b0}};
            dm_rdata_r <= {DATA_W{1'b0}};
        end else begin
            if_valid_r <= capture_s & (owner_r == OWNER_FETCH);
            dm_valid_r <= capture_s & (owner_r == OWNER_DATA);
            if (capture_s && (owner_r == OWNER_FETCH)) begin
                if_rdata_r <= mem_rdata;
            end else begin
                if_rdata_r <= if_rdata_r;
            end
            if (capture_s && (owner_r == OWNER_DATA) && !owner_we_r) begin
                dm_rdata_r <= mem_rdata;
            end else begin
                dm_rdata_r <= dm_rdata_r;
            end
        end
    end

    assign if_valid = if_valid_r;
    assign dm_valid = dm_valid_r;
    assign if_rdata = if_rdata_r;
    assign dm_rdata = dm_rdata_r;
    assign stall_f  = if_req & ~if_valid_r;
    assign stall_m  = dm_req & ~dm_valid_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios followed by a randomized run
// against a transaction-level reference (busy window + completion time).
module tb_mem_port_arbiter;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int LAT  = 2;
    localparam int MAXD = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          if_valid;
    logic          stall_f;
    logic          dm_req;
    logic          dm_we;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;
    logic [DW-1:0] dm_rdata;
    logic          dm_valid;
    logic          stall_m;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT), .MAX_DSTREAK(MAXD)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid), .stall_f(stall_f),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_valid(dm_valid), .stall_m(stall_m),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    // Power-up contents of the memory (before any write).
    function automatic logic [31:0] mem_init(input logic [31:0] a);
        if (a == 32'h0000_0010) return 32'hE3A0_0001;
        else return {a[15:0] ^ 16'h3C5A, ~a[15:0]};
    endfunction

    // Environment memory: word array plus a LAT-deep read pipeline that
    // returns noise whenever no read was issued.
    logic [31:0] env_arr [256];
    bit          env_wr  [256];
    logic [31:0] pipe    [LAT];
    assign mem_rdata = pipe[LAT-1];

    always @(posedge clk) begin
        if (mem_en === 1'b1 && mem_we === 1'b1) begin
            env_arr[mem_addr[9:2]] <= mem_wdata;
            env_wr[mem_addr[9:2]]  <= 1'b1;
        end
        if (mem_en === 1'b1 && mem_we === 1'b0)
            pipe[0] <= env_wr[mem_addr[9:2]] ? env_arr[mem_addr[9:2]] : mem_init(mem_addr);
        else
            pipe[0] <= $urandom;
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic do_reset();
        step();
        reset = 1'b0;
        if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
        repeat (3) step();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        if_req = 1'b1; if_addr = 32'h10;
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h40; dm_wdata = 32'h1234_5678;
        repeat (2) step();
        mid();
        checks++; if (mem_en !== 1'b0 || mem_we !== 1'b0) begin errors++; $display("FAIL rst_mem: en=%b we=%b exp 0 0", mem_en, mem_we); end
        checks++; if (if_valid !== 1'b0 || dm_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: if=%b dm=%b exp 0 0", if_valid, dm_valid); end
        checks++; if (if_rdata !== 32'h0 || dm_rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata: if=%h dm=%h exp 0", if_rdata, dm_rdata); end
        step();
        if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
        step();
        reset = 1'b1;
        mid();
        checks++; if (mem_en !== 1'b0 || stall_f !== 1'b0 || stall_m !== 1'b0) begin errors++; $display("FAIL rst_idle: en=%b sf=%b sm=%b exp 0", mem_en, stall_f, stall_m); end
    endtask

    task automatic test_fetch_single();
        step(); if_req = 1'b1; if_addr = 32'h10;
        mid();
        checks++; if (mem_en !== 1'b1 || mem_addr !== 32'h10 || mem_we !== 1'b0) begin errors++; $display("FAIL t1_grant: en=%b addr=%h we=%b exp 1 10 0", mem_en, mem_addr, mem_we); end
        checks++; if (stall_f !== 1'b1) begin errors++; $display("FAIL t1_stall_T: stall_f=%b exp 1", stall_f); end
        for (int k = 1; k <= 2; k++) begin
            step(); mid();
            checks++; if (mem_en !== 1'b0 || if_valid !== 1'b0 || stall_f !== 1'b1 || dm_valid !== 1'b0) begin
                errors++; $display("FAIL t1_wait%0d: en=%b ifv=%b sf=%b dmv=%b exp 0 0 1 0", k, mem_en, if_valid, stall_f, dm_valid); end
        end
        step(); mid();
        checks++; if (if_valid !== 1'b1 || if_rdata !== 32'hE3A0_0001) begin errors++; $display("FAIL t1_done: ifv=%b rdata=%h exp 1 e3a00001", if_valid, if_rdata); end
        checks++; if (stall_f !== 1'b0 || mem_en !== 1'b0) begin errors++; $display("FAIL t1_done_stall: sf=%b en=%b exp 0 0", stall_f, mem_en); end
        step(); if_req = 1'b0; mid();
        checks++; if (if_valid !== 1'b0 || if_rdata !== 32'hE3A0_0001) begin errors++; $display("FAIL t1_after: ifv=%b rdata=%h exp 0 e3a00001", if_valid, if_rdata); end
    endtask

    task automatic test_both_request();
        step();
        if_req = 1'b1; if_addr = 32'h20;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h80;
        mid();
        checks++; if (mem_en !== 1'b1 || mem_addr !== 32'h80 || mem_we !== 1'b0) begin errors++; $display("FAIL t2_dgrant: en=%b addr=%h we=%b exp 1 80 0", mem_en, mem_addr, mem_we); end
        repeat (2) begin step(); mid(); end
        step(); mid();
        checks++; if (dm_valid !== 1'b1 || dm_rdata !== mem_init(32'h80) || if_valid !== 1'b0) begin
            errors++; $display("FAIL t2_ddone: dmv=%b rdata=%h ifv=%b exp 1 %h 0", dm_valid, dm_rdata, if_valid, mem_init(32'h80)); end
        step(); dm_req = 1'b0; mid();
        checks++; if (mem_en !== 1'b1 || mem_addr !== 32'h20 || mem_we !== 1'b0) begin errors++; $display("FAIL t2_fgrant: en=%b addr=%h we=%b exp 1 20 0", mem_en, mem_addr, mem_we); end
        repeat (2) begin step(); mid(); end
        step(); mid();
        checks++; if (if_valid !== 1'b1 || if_rdata !== mem_init(32'h20) || dm_valid !== 1'b0) begin
            errors++; $display("FAIL t2_fdone: ifv=%b rdata=%h dmv=%b exp 1 %h 0", if_valid, if_rdata, dm_valid, mem_init(32'h20)); end
        step(); if_req = 1'b0;
    endtask

    task automatic test_write();
        step();
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h40; dm_wdata = 32'hDEAD_BEEF;
        mid();
        checks++; if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h40 || mem_wdata !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL t4_grant: en=%b we=%b addr=%h wdata=%h exp 1 1 40 deadbeef", mem_en, mem_we, mem_addr, mem_wdata); end
        for (int k = 1; k <= 2; k++) begin
            step(); mid();
            checks++; if (dm_valid !== 1'b0 || stall_m !== 1'b1) begin errors++; $display("FAIL t4_wait%0d: dmv=%b sm=%b exp 0 1", k, dm_valid, stall_m); end
        end
        step(); mid();
        checks++; if (dm_valid !== 1'b1 || dm_rdata !== mem_init(32'h80)) begin
            errors++; $display("FAIL t4_done: dmv=%b rdata=%h exp 1 %h", dm_valid, dm_rdata, mem_init(32'h80)); end
        step(); dm_req = 1'b0; mid();
        checks++; if (dm_valid !== 1'b0 || dm_rdata !== mem_init(32'h80)) begin
            errors++; $display("FAIL t4_hold: dmv=%b rdata=%h exp 0 %h", dm_valid, dm_rdata, mem_init(32'h80)); end
        step(); dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h40;
        repeat (3) begin mid(); step(); end
        mid();
        checks++; if (dm_valid !== 1'b1 || dm_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL t4_readback: dmv=%b rdata=%h exp 1 deadbeef", dm_valid, dm_rdata); end
        step(); dm_req = 1'b0;
    endtask

    task automatic test_dstreak();
        int d_idx;
        bit exp_data;
        logic [31:0] exp_addr;
        d_idx = 0;
        step();
        if_req = 1'b1; if_addr = 32'h20;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h100;
        for (int g = 0; g < 6; g++) begin
            mid();
            exp_data = (g != MAXD);
            exp_addr = exp_data ? 32'h100 + 32'(d_idx) * 32'd4 : 32'h20;
            checks++; if (mem_en !== 1'b1 || mem_addr !== exp_addr) begin
                errors++; $display("FAIL t3_grant%0d: en=%b addr=%h exp 1 %h", g, mem_en, mem_addr, exp_addr); end
            repeat (3) begin step(); mid(); end
            checks++; if (dm_valid !== exp_data || if_valid !== !exp_data) begin
                errors++; $display("FAIL t3_done%0d: dmv=%b ifv=%b exp %b %b", g, dm_valid, if_valid, exp_data, !exp_data); end
            step();
            if (exp_data) begin
                d_idx++;
                dm_addr = 32'h100 + 32'(d_idx) * 32'd4;
            end
        end
        if_req = 1'b0; dm_req = 1'b0;
    endtask

    task automatic test_reset_mid();
        step(); if_req = 1'b1; if_addr = 32'h10;
        mid();
        checks++; if (mem_en !== 1'b1) begin errors++; $display("FAIL t5_grant: en=%b exp 1", mem_en); end
        step(); reset = 1'b0; mid();
        checks++; if (mem_en !== 1'b0 || if_valid !== 1'b0 || if_rdata !== 32'h0) begin
            errors++; $display("FAIL t5_inrst: en=%b ifv=%b rdata=%h exp 0 0 0", mem_en, if_valid, if_rdata); end
        step(); mid();
        checks++; if (mem_en !== 1'b0 || if_valid !== 1'b0) begin errors++; $display("FAIL t5_inrst2: en=%b ifv=%b exp 0 0", mem_en, if_valid); end
        step(); reset = 1'b1; mid();
        checks++; if (mem_en !== 1'b1 || mem_addr !== 32'h10 || if_valid !== 1'b0) begin
            errors++; $display("FAIL t5_regrant: en=%b addr=%h ifv=%b exp 1 10 0", mem_en, mem_addr, if_valid); end
        for (int k = 1; k <= 2; k++) begin
            step(); mid();
            checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL t5_novalid%0d: ifv=%b exp 0", k, if_valid); end
        end
        step(); mid();
        checks++; if (if_valid !== 1'b1 || if_rdata !== 32'hE3A0_0001) begin errors++; $display("FAIL t5_done: ifv=%b rdata=%h exp 1 e3a00001", if_valid, if_rdata); end
        step(); if_req = 1'b0;
    endtask

    task automatic test_drop_req();
        step(); if_req = 1'b1; if_addr = 32'h20;
        mid();
        checks++; if (mem_en !== 1'b1 || mem_addr !== 32'h20) begin errors++; $display("FAIL t6_grant: en=%b addr=%h exp 1 20", mem_en, mem_addr); end
        step(); if_req = 1'b0; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h80;
        mid();
        checks++; if (mem_en !== 1'b0 || dm_valid !== 1'b0) begin errors++; $display("FAIL t6_busy: en=%b dmv=%b exp 0 0", mem_en, dm_valid); end
        step(); mid();
        step(); mid();
        checks++; if (if_valid !== 1'b1 || if_rdata !== mem_init(32'h20) || dm_valid !== 1'b0 || mem_en !== 1'b0) begin
            errors++; $display("FAIL t6_done: ifv=%b rdata=%h dmv=%b en=%b exp 1 %h 0 0", if_valid, if_rdata, dm_valid, mem_en, mem_init(32'h20)); end
        step(); mid();
        checks++; if (mem_en !== 1'b1 || mem_addr !== 32'h80 || if_valid !== 1'b0) begin
            errors++; $display("FAIL t6_next: en=%b addr=%h ifv=%b exp 1 80 0", mem_en, mem_addr, if_valid); end
        repeat (2) begin step(); mid(); end
        step(); mid();
        checks++; if (dm_valid !== 1'b1 || dm_rdata !== mem_init(32'h80)) begin errors++; $display("FAIL t6_ddone: dmv=%b rdata=%h exp 1 %h", dm_valid, dm_rdata, mem_init(32'h80)); end
        step(); dm_req = 1'b0;
    endtask

    // Reference-model state for the randomized run.
    logic [31:0] m_mem [256];
    bit          m_wr  [256];

    task automatic test_random();
        bit m_busy, m_fin, m_owner_d, m_we, ev_if, ev_dm, e_en, d_win, prev_ifv, prev_dmv;
        int m_done, m_dstreak, cyc;
        logic [31:0] m_data, e_if_rdata, e_dm_rdata;
        logic [7:0] idx;
        for (int i = 0; i < 256; i++) m_wr[i] = 1'b0;
        do_reset();
        m_busy = 0; m_dstreak = 0; m_done = 0; m_owner_d = 0; m_we = 0; m_data = 32'h0;
        e_if_rdata = 32'h0; e_dm_rdata = 32'h0; prev_ifv = 0; prev_dmv = 0;
        for (cyc = 0; cyc < 1500; cyc++) begin
            if (cyc != 0) step();
            // Requesters: hold until completion, then drop or reissue.
            if (if_req && prev_ifv) begin
                if ($urandom_range(0, 1) == 0) if_req = 1'b0;
                else if_addr = 32'h200 + 32'($urandom_range(0, 15)) * 32'd4;
            end else if (!if_req && $urandom_range(0, 2) == 0) begin
                if_req = 1'b1; if_addr = 32'h200 + 32'($urandom_range(0, 15)) * 32'd4;
            end
            if ((dm_req && prev_dmv) || (!dm_req && $urandom_range(0, 2) == 0)) begin
                if (dm_req && $urandom_range(0, 3) == 0) dm_req = 1'b0;
                else begin
                    dm_req = 1'b1; dm_we = ($urandom_range(0, 2) == 0);
                    dm_addr = 32'h200 + 32'($urandom_range(0, 15)) * 32'd4; dm_wdata = $urandom;
                end
            end
            mid();
            m_fin = 0; ev_if = 0; ev_dm = 0;
            if (m_busy && cyc == m_done) begin
                m_fin = 1;
                if (m_owner_d) begin ev_dm = 1; if (!m_we) e_dm_rdata = m_data; end
                else begin ev_if = 1; e_if_rdata = m_data; end
            end
            e_en = !m_busy && (if_req || dm_req);
            checks++; if (mem_en !== e_en) begin errors++; $display("FAIL rnd_en c%0d: %b exp %b", cyc, mem_en, e_en); end
            checks++; if (if_valid !== ev_if || dm_valid !== ev_dm) begin errors++; $display("FAIL rnd_valid c%0d: if=%b dm=%b exp %b %b", cyc, if_valid, dm_valid, ev_if, ev_dm); end
            checks++; if (if_rdata !== e_if_rdata || dm_rdata !== e_dm_rdata) begin
                errors++; $display("FAIL rnd_rdata c%0d: if=%h dm=%h exp %h %h", cyc, if_rdata, dm_rdata, e_if_rdata, e_dm_rdata); end
            checks++; if (stall_f !== (if_req && !ev_if) || stall_m !== (dm_req && !ev_dm)) begin
                errors++; $display("FAIL rnd_stall c%0d: sf=%b sm=%b", cyc, stall_f, stall_m); end
            if (e_en) begin
                d_win = dm_req && (!if_req || m_dstreak < MAXD);
                if (d_win) begin
                    idx = dm_addr[9:2];
                    checks++; if (mem_addr !== dm_addr || mem_we !== dm_we || (dm_we && mem_wdata !== dm_wdata)) begin
                        errors++; $display("FAIL rnd_dport c%0d: addr=%h we=%b wd=%h exp %h %b %h", cyc, mem_addr, mem_we, mem_wdata, dm_addr, dm_we, dm_wdata); end
                    if (dm_we) begin m_mem[idx] = dm_wdata; m_wr[idx] = 1'b1; end
                    else m_data = m_wr[idx] ? m_mem[idx] : mem_init(dm_addr);
                    m_dstreak = if_req ? ((m_dstreak < MAXD) ? m_dstreak + 1 : MAXD) : 0;
                end else begin
                    idx = if_addr[9:2];
                    checks++; if (mem_addr !== if_addr || mem_we !== 1'b0) begin
                        errors++; $display("FAIL rnd_fport c%0d: addr=%h we=%b exp %h 0", cyc, mem_addr, mem_we, if_addr); end
                    m_data = m_wr[idx] ? m_mem[idx] : mem_init(if_addr);
                    m_dstreak = 0;
                end
                m_busy = 1; m_done = cyc + LAT + 1; m_owner_d = d_win; m_we = d_win && dm_we;
            end else if (m_fin) begin
                m_busy = 0;
            end
            prev_ifv = if_valid; prev_dmv = dm_valid;
        end
        step(); if_req = 1'b0; dm_req = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        if_req = 1'b0; if_addr = 32'h0;
        dm_req = 1'b0; dm_we = 1'b0; dm_addr = 32'h0; dm_wdata = 32'h0;
        test_reset();
        test_fetch_single();
        test_both_request();
        test_write();
        do_reset();
        test_dstreak();
        repeat (4) step();
        test_reset_mid();
        test_drop_req();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
